// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch stage between a combinational instruction memory and decode.
// Holds the PC and reads one word per cycle into a 2-entry {pc, instr} queue. Decode
// back-pressure stalls the PC, so no word is lost. A branch redirect flushes the queue.
// Fetching stops once a HALT word has been fetched.
//
// Ports:
//   clk, reset       clock (rising edge), asynchronous active-high reset
//   imem_addr        word address to instruction memory (pc zero-extended)
//   imem_data        instruction returned combinationally for imem_addr
//   redirect_valid   one-cycle redirect request
//   redirect_target  new word address (low ADDR_WIDTH bits used)
//   out_valid        queue head valid
//   out_ready        decode accepts head this cycle
//   out_instr        head instruction (0 when not valid)
//   out_pc           head word address, zero-extended (0 when not valid)
//   halted           sticky: HALT has been delivered to decode
module instruction_fetch #(
  parameter int unsigned           ADDR_WIDTH  = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [3:0]            HALT_OPCODE = 4'h6
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        halted
);

  localparam int unsigned PadW = 32 - ADDR_WIDTH;

  typedef enum logic [1:0] {StFetch, StHaltSeen, StHalted} state_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [31:0]           instr;
  } entry_t;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [1:0]            count_q, count_d;
  entry_t                ent_q [2];
  entry_t                ent_d [2];

  logic       pop;
  logic       fetch_en;
  logic       is_halt;
  logic [1:0] count_after_pop;

  // Upper target bits are ignored by design.
  logic unused_target;
  assign unused_target = ^redirect_target[31:ADDR_WIDTH];

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    count_d         = count_q;
    ent_d[0]        = ent_q[0];
    ent_d[1]        = ent_q[1];
    pop             = (state_q != StHalted) && (count_q != 2'd0) && out_ready;
    // A full queue can still accept a word when its head leaves this cycle.
    fetch_en        = (state_q == StFetch) && !redirect_valid && ((count_q != 2'd2) || pop);
    is_halt         = (imem_data[31:28] == HALT_OPCODE);
    count_after_pop = count_q - {1'b0, pop};

    if (redirect_valid && (state_q != StHalted)) begin
      // Any same-cycle pop is already delivered; everything else is stale.
      count_d = 2'd0;
      pc_d    = redirect_target[ADDR_WIDTH-1:0];
      state_d = StFetch;
    end else begin
      if (pop) begin
        ent_d[0] = ent_q[1];
      end
      if (fetch_en) begin
        // count_after_pop is at most 1 here, so bit 0 selects the free slot.
        ent_d[count_after_pop[0]] = '{pc: pc_q, instr: imem_data};
        count_d                   = count_after_pop + 2'd1;
        if (is_halt) begin
          state_d = StHaltSeen;
        end else begin
          pc_d = pc_q + 1'b1;
        end
      end else begin
        count_d = count_after_pop;
      end
      // In HaltSeen the HALT is always the last queued entry.
      if ((state_q == StHaltSeen) && pop && (count_q == 2'd1)) begin
        state_d = StHalted;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StFetch;
      pc_q     <= RESET_PC;
      count_q  <= 2'd0;
      ent_q[0] <= '0;
      ent_q[1] <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      count_q  <= count_d;
      ent_q[0] <= ent_d[0];
      ent_q[1] <= ent_d[1];
    end
  end

  // Outputs depend only on registered state.
  assign imem_addr = {{PadW{1'b0}}, pc_q};
  assign out_valid = (count_q != 2'd0) && (state_q != StHalted);
  assign out_instr = out_valid ? ent_q[0].instr : 32'd0;
  assign out_pc    = out_valid ? {{PadW{1'b0}}, ent_q[0].pc} : 32'd0;
  assign halted    = (state_q == StHalted);

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] imem_addr, imem_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_instr, out_pc;
  logic        halted;

  logic        reset2 = 1'b1;
  logic [31:0] imem_addr2, imem_data2;
  logic        out_valid2;
  logic [31:0] out_instr2, out_pc2;
  logic        halted2;

  logic [31:0] mem [256];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_data  = mem[imem_addr[7:0]];
  assign imem_data2 = mem[imem_addr2[7:0]];

  instruction_fetch dut (
    .clk             (clk),
    .reset           (reset),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instr       (out_instr),
    .out_pc          (out_pc),
    .halted          (halted)
  );

  instruction_fetch #(.RESET_PC(8'd255)) dut2 (
    .clk             (clk),
    .reset           (reset2),
    .imem_addr       (imem_addr2),
    .imem_data       (imem_data2),
    .redirect_valid  (1'b0),
    .redirect_target (32'd0),
    .out_valid       (out_valid2),
    .out_ready       (1'b1),
    .out_instr       (out_instr2),
    .out_pc          (out_pc2),
    .halted          (halted2)
  );

  // Reference model: a queue of delivered-order words plus fetch/halt flags.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t     q[$];
  logic [7:0] mpc;
  bit       mpend;
  bit       mhalted;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input logic [7:0] rpc);
    q.delete();
    mpc     = rpc;
    mpend   = 1'b0;
    mhalted = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    bit          ev;
    logic [31:0] ei, ep;
    ev = !mhalted && (q.size() > 0);
    ei = 32'd0;
    ep = 32'd0;
    if (ev) begin
      ei = q[0].instr;
      ep = q[0].pc;
    end
    check({tag, " out_valid"}, {31'd0, out_valid}, {31'd0, ev});
    check({tag, " out_instr"}, out_instr, ei);
    check({tag, " out_pc"}, out_pc, ep);
    check({tag, " halted"}, {31'd0, halted}, {31'd0, mhalted});
    check({tag, " imem_addr"}, imem_addr, {24'd0, mpc});
  endtask

  task automatic model_step(input bit rv, input logic [31:0] rt, input bit rdy);
    bit   pop;
    ent_t e;
    pop = !mhalted && (q.size() > 0) && rdy;
    if (mhalted) begin
      // terminal until reset
    end else if (rv) begin
      q.delete();
      mpc   = rt[7:0];
      mpend = 1'b0;
    end else begin
      if (pop) begin
        e = q.pop_front();
        if (e.instr[31:28] == 4'h6) mhalted = 1'b1;
      end
      if (!mpend && !mhalted && q.size() < 2) begin
        e.pc    = {24'd0, mpc};
        e.instr = mem[mpc];
        q.push_back(e);
        if (mem[mpc][31:28] == 4'h6) mpend = 1'b1;
        else mpc = mpc + 8'd1;
      end
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle(input bit rv, input logic [31:0] rt, input bit rdy);
    redirect_valid  = rv;
    redirect_target = rt;
    out_ready       = rdy;
    check_outputs("cyc");
    model_step(rv, rt, rdy);
    @(negedge clk);
  endtask

  task automatic do_reset();
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    reset          = 1'b1;
    #1;
    model_reset(8'd0);
    check_outputs("reset");
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    for (int i = 3; i < 9; i++) if (mem[i][31:28] == 4'h6) mem[i][31:28] = 4'h7;
    mem[0]   = 32'h22000017;
    mem[1]   = 32'h26200017;
    mem[2]   = 32'h26600017;
    mem[7]   = 32'h34000003;
    mem[9]   = 32'h60000004;
    mem[255] = 32'h12345678;

    @(negedge clk);

    // RESET_PC = 255: wrap, then asynchronous reset mid-stream with clk low.
    reset2 = 1'b0;
    @(negedge clk);
    check("wrap pc255", out_pc2, 32'd255);
    check("wrap instr255", out_instr2, 32'h12345678);
    @(negedge clk);
    check("wrap pc0", out_pc2, 32'd0);
    check("wrap instr0", out_instr2, 32'h22000017);
    @(negedge clk);
    reset2 = 1'b1;
    #1;
    check("async rst valid", {31'd0, out_valid2}, 32'd0);
    check("async rst halted", {31'd0, halted2}, 32'd0);
    check("async rst addr", imem_addr2, 32'd255);
    @(negedge clk);

    // Streaming, back-pressure and halt.
    do_reset();
    cycle(1'b0, 32'd0, 1'b1);
    check("first pc", out_pc, 32'd0);
    check("first instr", out_instr, 32'h22000017);
    repeat (3) cycle(1'b0, 32'd0, 1'b0);
    check("bp addr", imem_addr, 32'd2);
    check("bp head", out_pc, 32'd0);
    repeat (9) cycle(1'b0, 32'd0, 1'b1);
    check("halt pc", out_pc, 32'd9);
    check("halt instr", out_instr, 32'h60000004);
    cycle(1'b0, 32'd0, 1'b1);
    check("halted", {31'd0, halted}, 32'd1);
    check("halted valid", {31'd0, out_valid}, 32'd0);
    check("halted addr", imem_addr, 32'd9);
    cycle(1'b1, 32'd3, 1'b1);
    cycle(1'b0, 32'd0, 1'b1);
    check("halted redirect addr", imem_addr, 32'd9);

    // Redirect with a full queue holding pc 2 and 3.
    do_reset();
    repeat (3) cycle(1'b0, 32'd0, 1'b1);
    cycle(1'b0, 32'd0, 1'b0);
    check("full head", out_pc, 32'd2);
    cycle(1'b1, 32'd7, 1'b0);
    cycle(1'b0, 32'd0, 1'b1);
    check("redir pc", out_pc, 32'd7);
    check("redir instr", out_instr, 32'h34000003);
    cycle(1'b0, 32'd0, 1'b1);
    check("redir next", out_pc, 32'd8);

    // Redirect while the HALT is queued.
    do_reset();
    cycle(1'b1, 32'd8, 1'b0);
    repeat (2) cycle(1'b0, 32'd0, 1'b0);
    cycle(1'b1, 32'd5, 1'b0);
    repeat (3) cycle(1'b0, 32'd0, 1'b1);
    check("hs halted", {31'd0, halted}, 32'd0);
    check("hs pc", out_pc, 32'd7);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      if (mhalted && ($urandom % 4 == 0)) do_reset();
      else cycle(($urandom % 8) == 0, $urandom, ($urandom % 4) != 0);
    end
    check_outputs("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
